// File: rtl/sample_stream_pkg.sv
// rtl/sample_stream_pkg.sv - shared mode type, widths and parameter checks for the sample stream FIFO
package sample_stream_pkg;

  typedef enum logic [0:0] {
    STREAM_MODE_BACKPRESSURE = 1'b0,
    STREAM_MODE_DROP         = 1'b1
  } stream_mode_e;

  localparam int DROP_COUNT_WIDTH = 8;

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sample_stream_ram.sv
// rtl/sample_stream_ram.sv - DEPTH x DATA_WIDTH register array, synchronous write, asynchronous read
module sample_stream_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sample_stream_fifo.sv
// rtl/sample_stream_fifo.sv - valid/ready stream FIFO with occupancy, almost-full and drop-on-full counting
module sample_stream_fifo
  import sample_stream_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int DEPTH             = 4,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
  parameter int MODE              = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stream_in_valid,
  output logic                        stream_in_ready,
  input  logic [DATA_WIDTH-1:0]       stream_in_data,
  output logic                        stream_out_valid,
  input  logic                        stream_out_ready,
  output logic [DATA_WIDTH-1:0]       stream_out_data,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic                        almost_full,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam bit DROP_MODE = (MODE == int'(STREAM_MODE_DROP));

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sample_stream_fifo: DEPTH must be a power of two >= 2");
  end
  if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_afl
    $error("sample_stream_fifo: ALMOST_FULL_LEVEL must lie in 1..DEPTH");
  end
  if (MODE != int'(STREAM_MODE_BACKPRESSURE) && MODE != int'(STREAM_MODE_DROP)) begin : g_bad_mode
    $error("sample_stream_fifo: MODE must be 0 or 1");
  end

  logic [AW-1:0]               r_wr_ptr;
  logic [AW-1:0]               r_rd_ptr;
  logic [LW-1:0]               r_level;
  logic [DROP_COUNT_WIDTH-1:0] r_drop_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_store;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // In drop mode ready never depends on occupancy; overflow is resolved after acceptance.
  assign w_in_ready = !rst && (DROP_MODE || !w_full);
  assign w_accept   = stream_in_valid && w_in_ready;
  assign w_pop      = stream_out_ready && !w_empty && !rst;
  assign w_store    = w_accept && (!w_full || w_pop);
  assign w_drop     = w_accept && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= r_level + LW'(w_store) - LW'(w_pop);
      if (w_drop && (r_drop_count != '1)) begin
        r_drop_count <= r_drop_count + DROP_COUNT_WIDTH'(1);
      end
    end
  end

  sample_stream_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (w_store),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (stream_in_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign stream_in_ready  = w_in_ready;
  assign stream_out_valid = !w_empty;
  assign stream_out_data  = w_empty ? '0 : w_rd_data;
  assign level            = r_level;
  assign almost_full      = (r_level >= LW'(ALMOST_FULL_LEVEL));
  assign drop_count       = r_drop_count;

endmodule

// File: tb/tb_sample_stream_fifo.sv
// tb/tb_sample_stream_fifo.sv - scoreboard bench over backpressure, drop-mode and wide random FIFO instances
module tb_sample_stream_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [63:0] in_data   [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [63:0] out_data  [3];
  logic [4:0]  lvl       [3];
  logic        afull     [3];
  logic [7:0]  drop      [3];

  logic [2:0]  lvl0, lvl1;
  logic [4:0]  lvl2;
  logic [7:0]  od0, od1;
  logic [63:0] od2;

  assign lvl[0] = {2'b00, lvl0};
  assign lvl[1] = {2'b00, lvl1};
  assign lvl[2] = lvl2;
  assign out_data[0] = {56'd0, od0};
  assign out_data[1] = {56'd0, od1};
  assign out_data[2] = od2;

  sample_stream_fifo #(.DATA_WIDTH(8), .DEPTH(4), .ALMOST_FULL_LEVEL(3), .MODE(0)) u_bp (
    .clk(clk), .rst(rst),
    .stream_in_valid(in_valid[0]), .stream_in_ready(in_ready[0]), .stream_in_data(in_data[0][7:0]),
    .stream_out_valid(out_valid[0]), .stream_out_ready(out_ready[0]), .stream_out_data(od0),
    .level(lvl0), .almost_full(afull[0]), .drop_count(drop[0])
  );

  sample_stream_fifo #(.DATA_WIDTH(8), .DEPTH(4), .MODE(1)) u_drop (
    .clk(clk), .rst(rst),
    .stream_in_valid(in_valid[1]), .stream_in_ready(in_ready[1]), .stream_in_data(in_data[1][7:0]),
    .stream_out_valid(out_valid[1]), .stream_out_ready(out_ready[1]), .stream_out_data(od1),
    .level(lvl1), .almost_full(afull[1]), .drop_count(drop[1])
  );

  sample_stream_fifo #(.DATA_WIDTH(64), .DEPTH(16), .MODE(0)) u_rand (
    .clk(clk), .rst(rst),
    .stream_in_valid(in_valid[2]), .stream_in_ready(in_ready[2]), .stream_in_data(in_data[2]),
    .stream_out_valid(out_valid[2]), .stream_out_ready(out_ready[2]), .stream_out_data(od2),
    .level(lvl2), .almost_full(afull[2]), .drop_count(drop[2])
  );

  function automatic int dep_of(input int i);
    return (i == 2) ? 16 : 4;
  endfunction

  function automatic int afl_of(input int i);
    return dep_of(i) - 1;
  endfunction

  function automatic bit drop_mode_of(input int i);
    return (i == 1);
  endfunction

  function automatic logic [63:0] mask_of(input int i);
    return (i == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_00FF;
  endfunction

  // Reference model: one queue of stored words and one drop tally per instance.
  logic [63:0] mq [3][$];
  int          mdrop [3];
  bit          armed = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h", name, i, $time, act, exp);
    end
  endtask

  int          sz;
  bit          m_pop;
  bit          m_full;
  logic [63:0] head;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      sz   = mq[i].size();
      head = (sz > 0) ? mq[i][0] : 64'd0;
      if (armed) begin
        chk("level", i, 64'(lvl[i]), 64'(sz));
        chk("level_bound", i, 64'(lvl[i] <= 5'(dep_of(i))), 64'd1);
        chk("almost_full", i, 64'(afull[i]), 64'(sz >= afl_of(i)));
        chk("out_valid", i, 64'(out_valid[i]), 64'(sz > 0));
        chk("out_data", i, out_data[i], head);
        chk("drop_count", i, 64'(drop[i]), 64'(mdrop[i]));
        chk("in_ready", i, 64'(in_ready[i]),
            64'(!rst && (drop_mode_of(i) || sz < dep_of(i))));
      end
      if (rst) begin
        mq[i].delete();
        mdrop[i] = 0;
      end else if (armed) begin
        m_pop  = out_ready[i] && (sz > 0);
        m_full = (sz == dep_of(i));
        if (m_pop) void'(mq[i].pop_front());
        if (in_valid[i]) begin
          if (!m_full || (drop_mode_of(i) && m_pop)) begin
            mq[i].push_back(in_data[i] & mask_of(i));
          end else if (drop_mode_of(i) && mdrop[i] < 255) begin
            mdrop[i]++;
          end
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit pending;
  int pv, pr;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      in_data[i]   = 64'd0;
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Backpressure: fill, hold a word while full, pop with push pending, then drain.
    for (int k = 0; k < 4; k++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 64'((k + 1) * 'h11);
      tick();
    end
    in_data[0] = 64'h55;
    repeat (2) tick();
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    tick();
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    repeat (6) tick();
    out_ready[0] = 1'b0;

    // Drop mode: fill, overflow 300 words, push-with-pop while full, drain.
    for (int k = 0; k < 4; k++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = 64'(8'hA1 + k);
      tick();
    end
    for (int k = 0; k < 300; k++) begin
      in_data[1] = 64'($urandom_range(0, 255));
      tick();
    end
    in_data[1]   = 64'hB0;
    out_ready[1] = 1'b1;
    tick();
    in_valid[1] = 1'b0;
    repeat (6) tick();
    out_ready[1] = 1'b0;

    // Wide random traffic with shifting bias and a mid-run reset.
    pending = 1'b0;
    pv = 60;
    pr = 55;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        pv = $urandom_range(20, 95);
        pr = $urandom_range(20, 95);
      end
      if (c == 5000) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      if (!pending) begin
        in_valid[2] = ($urandom_range(0, 99) < pv);
        in_data[2]  = {$urandom, $urandom};
      end
      out_ready[2] = ($urandom_range(0, 99) < pr);
      @(negedge clk);
      pending = in_valid[2] && !in_ready[2];
      tick();
    end
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b1;
    repeat (20) tick();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
